if_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the cpu decode/execute datapath.
- Generates sequential instruction addresses and issues requests to instruction memory over a req/gnt/rvalid protocol with variable latency.
- Buffers returned instructions in a small prefetch FIFO and presents them downstream with a valid/ready handshake.
- On a taken branch (redirect), flushes the FIFO and discards in-flight responses.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fifo.sv | 56 +++++
 rtl/if_fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit and the cpu datapath.
package ifu_pkg;

    localparam int IFU_INSTR_W    = 18;
    localparam int IFU_PC_W       = 14;
    localparam int IFU_FIFO_DEPTH = 4;
    localparam logic [IFU_PC_W-1:0] IFU_RESET_PC = 14'h2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO with flush; head is read combinationally, storage is not reset.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (i_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (i_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Push while full is legal together with a pop: the write lands in the slot being vacated.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = mem[rd_ptr_q[AW-1:0]];
    assign o_count = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequential req/gnt/rvalid fetch, prefetch FIFO, redirect flush and drain.
// Define IFU_PERF_CNT_EN to add saturating fetched/flushed/stall performance counters.
module if_fetch_unit
    import ifu_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = IFU_INSTR_W,
    parameter int PC_WIDTH          = IFU_PC_W,
    parameter int FIFO_DEPTH        = IFU_FIFO_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    output logic                         o_imem_req,
    output logic [PC_WIDTH-1:0]          o_imem_addr,
    input  logic                         i_imem_gnt,
    input  logic                         i_imem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
    input  logic                         i_redirect,
    input  logic [PC_WIDTH-1:0]          i_redirect_pc,
    output logic                         o_inst_valid,
    output logic [INSTRUCTION_WIDTH-1:0] o_inst,
    output logic [PC_WIDTH-1:0]          o_inst_pc,
    input  logic                         i_inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]                  o_perf_fetched,
    output logic [31:0]                  o_perf_flushed,
    output logic [31:0]                  o_perf_stall
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    ifu_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]          outstanding_q, outstanding_d;
    logic [CW-1:0]          drop_q, drop_d;
    logic [AW-1:0]          tag_wr_q, tag_wr_d;
    logic [AW-1:0]          tag_rd_q, tag_rd_d;
    logic [PC_WIDTH-1:0]    tag_mem [FIFO_DEPTH];

    logic                   redirect_act, credit_ok, imem_req, issue, accept, inst_valid, pop;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full, fifo_empty;
    logic [INSTRUCTION_WIDTH+PC_WIDTH-1:0] fifo_rdata;

    assign redirect_act = i_redirect && (state_q != IDLE);
    assign credit_ok    = !fifo_full &&
                          (((CW+1)'(fifo_count) + (CW+1)'(outstanding_q)) < (CW+1)'(FIFO_DEPTH));
    assign imem_req     = (state_q == FETCH) && !i_redirect && credit_ok;
    assign issue        = imem_req && i_imem_gnt;
    assign accept       = i_imem_rvalid && (state_q == FETCH) && !i_redirect;
    assign inst_valid   = !fifo_empty && !redirect_act;
    assign pop          = inst_valid && i_inst_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(i_imem_rvalid);
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        if (redirect_act) begin
            tag_wr_d = '0;
            tag_rd_d = '0;
        end else begin
            if (issue)  tag_wr_d = tag_wr_q + AW'(1);
            if (accept) tag_rd_d = tag_rd_q + AW'(1);
        end
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (issue) fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
                // Everything still in flight at a redirect belongs to the old path.
                if (i_redirect) begin
                    fetch_pc_d = i_redirect_pc;
                    if (outstanding_d != '0) begin
                        state_d = DRAIN;
                        drop_d  = outstanding_d;
                    end
                end
            end
            DRAIN: begin
                if (i_imem_rvalid) drop_d = drop_q - CW'(1);
                if (i_redirect)    fetch_pc_d = i_redirect_pc;
                if (drop_d == '0)  state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (issue) tag_mem[tag_wr_q] <= fetch_pc_q;
    end

    ifu_fifo #(
        .WIDTH(INSTRUCTION_WIDTH + PC_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (redirect_act),
        .i_push  (accept),
        .i_wdata ({i_imem_rdata, tag_mem[tag_rd_q]}),
        .i_pop   (pop),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_imem_req   = imem_req;
    assign o_imem_addr  = fetch_pc_q;
    assign o_inst_valid = inst_valid;
    assign o_inst       = inst_valid ? fifo_rdata[INSTRUCTION_WIDTH+PC_WIDTH-1:PC_WIDTH] : '0;
    assign o_inst_pc    = inst_valid ? fifo_rdata[PC_WIDTH-1:0] : '0;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        dropped;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, v} + 33'(inc);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign dropped = i_imem_rvalid && (state_q != IDLE) && !accept;

    always_comb begin
        perf_fetched_d = sat_add(perf_fetched_q, {1'b0, accept});
        perf_flushed_d = sat_add(perf_flushed_q, 2'(redirect_act) + 2'(dropped));
        perf_stall_d   = sat_add(perf_stall_q, {1'b0, (state_q == FETCH) && !inst_valid});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_flushed = perf_flushed_q;
    assign o_perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order variable-latency memory model plus a queue-based reference.
module tb_if_fetch_unit;

    localparam int IW    = 18;
    localparam int PW    = 14;
    localparam int DEPTH = 4;
    localparam logic [PW-1:0] RST_PC = 14'h2000;

    logic          clk;
    logic          rst_n;
    logic          o_imem_req;
    logic [PW-1:0] o_imem_addr;
    logic          i_imem_gnt;
    logic          i_imem_rvalid;
    logic [IW-1:0] i_imem_rdata;
    logic          i_redirect;
    logic [PW-1:0] i_redirect_pc;
    logic          o_inst_valid;
    logic [IW-1:0] o_inst;
    logic [PW-1:0] o_inst_pc;
    logic          i_inst_ready;

    if_fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] addr;
        int            due;
        bit            stale;
    } req_t;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    req_t          memq[$];   // requests accepted by memory, oldest first
    ent_t          reff[$];   // instructions decode should see, oldest first
    logic [PW-1:0] dlv[$];    // pcs actually handed to decode
    logic [PW-1:0] ref_pc;
    bit            started;
    bit            rand_gnt;
    bit            smp_valid;
    int            lat_min, lat_max;
    int            cyc;
    int            n_issue;
    int            checks;
    int            failures;

    function automatic logic [IW-1:0] mem_data(input logic [PW-1:0] a);
        return {a[3:0], a} ^ 18'h15A5A;
    endfunction

    function automatic bit stale_inflight();
        foreach (memq[i]) if (memq[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check outputs mid-cycle, advance the reference, then drive the memory side.
    task automatic cycle();
        bit   exp_req, exp_valid, red, have_push;
        ent_t e;
        req_t r;
        @(negedge clk);
        red       = i_redirect && started;
        exp_req   = started && !i_redirect && !stale_inflight() &&
                    ((reff.size() + memq.size()) < DEPTH);
        exp_valid = (reff.size() > 0) && !red;
        checks++;
        if (o_imem_req !== exp_req) begin
            failures++;
            $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, o_imem_req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (o_imem_addr !== ref_pc) begin
                failures++;
                $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, o_imem_addr, ref_pc);
            end
        end
        checks++;
        if (o_inst_valid !== exp_valid) begin
            failures++;
            $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, o_inst_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (o_inst_pc !== reff[0].pc || o_inst !== reff[0].inst) begin
                failures++;
                $display("FAIL inst_head cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                         cyc, o_inst_pc, o_inst, reff[0].pc, reff[0].inst);
            end
        end
        smp_valid = o_inst_valid;
        if (o_inst_valid && i_inst_ready) dlv.push_back(o_inst_pc);
        if (o_imem_req && i_imem_gnt) n_issue++;

        have_push = 1'b0;
        if (i_imem_rvalid) begin
            if (memq.size() == 0) begin
                failures++;
                $display("FAIL protocol cyc=%0d: rvalid with nothing outstanding", cyc);
            end else begin
                r = memq.pop_front();
                if (!r.stale && !red) begin
                    e.pc      = r.addr;
                    e.inst    = mem_data(r.addr);
                    have_push = 1'b1;
                end
            end
        end
        if (exp_valid && i_inst_ready) void'(reff.pop_front());
        if (have_push) reff.push_back(e);
        if (exp_req && i_imem_gnt) begin
            r.addr  = ref_pc;
            r.due   = cyc + int'($urandom_range(lat_max, lat_min));
            r.stale = 1'b0;
            memq.push_back(r);
            ref_pc = ref_pc + 1'b1;
        end
        if (red) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            reff.delete();
            ref_pc = i_redirect_pc;
        end
        started = 1'b1;

        @(posedge clk);
        cyc++;
        #1;
        i_redirect = 1'b0;
        i_imem_gnt = rand_gnt ? 1'($urandom_range(1, 0)) : 1'b1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_data(memq[0].addr);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = IW'($urandom);
        end
    endtask

    // Assert reset (asynchronously, mid-cycle) and check outputs before the next edge.
    task automatic apply_reset(input int hold);
        rst_n         = 1'b0;
        i_imem_rvalid = 1'b0;
        i_redirect    = 1'b0;
        i_imem_gnt    = 1'b1;
        memq.delete();
        reff.delete();
        ref_pc  = RST_PC;
        started = 1'b0;
        @(negedge clk);
        checks += 5;
        if (o_imem_req !== 1'b0) begin
            failures++; $display("FAIL rst_req: got %b expected 0", o_imem_req);
        end
        if (o_inst_valid !== 1'b0) begin
            failures++; $display("FAIL rst_valid: got %b expected 0", o_inst_valid);
        end
        if (o_inst !== '0) begin
            failures++; $display("FAIL rst_inst: got %h expected 0", o_inst);
        end
        if (o_inst_pc !== '0) begin
            failures++; $display("FAIL rst_inst_pc: got %h expected 0", o_inst_pc);
        end
        if (o_imem_addr !== RST_PC) begin
            failures++; $display("FAIL rst_addr: got %h expected %h", o_imem_addr, RST_PC);
        end
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(2);
    endtask

    task automatic test_sequential();
        int first, nvalid;
        apply_reset(1);
        rand_gnt = 0; lat_min = 1; lat_max = 1; i_inst_ready = 1'b1;
        first = -1; nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (smp_valid) begin
                nvalid++;
                if (first < 0) first = k;
            end
        end
        checks += 2;
        if (first !== 3) begin
            failures++; $display("FAIL first_valid_cycle: got %0d expected 3", first);
        end
        if (nvalid !== 17) begin
            failures++; $display("FAIL throughput: got %0d valid cycles expected 17", nvalid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1);
        rand_gnt = 0; lat_min = 1; lat_max = 1; i_inst_ready = 1'b0;
        n_issue = 0;
        repeat (12) cycle();
        checks++;
        if (n_issue !== DEPTH) begin
            failures++; $display("FAIL credit_limit: got %0d issues expected %0d", n_issue, DEPTH);
        end
        i_inst_ready = 1'b1;
        dlv.delete();
        repeat (12) cycle();
        checks++;
        if (dlv.size() < 5 || dlv[0] !== 14'h2000 || dlv[3] !== 14'h2003 || dlv[4] !== 14'h2004) begin
            failures++;
            $display("FAIL bp_order: got %0d pops first=%h expected 2000..2004 in order",
                     dlv.size(), (dlv.size() > 0) ? dlv[0] : 14'h0);
        end
    endtask

    task automatic test_drain();
        apply_reset(1);
        rand_gnt = 0; lat_min = 3; lat_max = 3; i_inst_ready = 1'b1;
        repeat (8) cycle();
        i_redirect = 1'b1; i_redirect_pc = 14'h0100;
        dlv.delete();
        repeat (20) cycle();
        checks++;
        if (dlv.size() == 0 || dlv[0] !== 14'h0100) begin
            failures++;
            $display("FAIL drain_target: got %h expected 0100", (dlv.size() > 0) ? dlv[0] : 14'h0);
        end
    endtask

    task automatic test_redirect_collide();
        apply_reset(1);
        rand_gnt = 0; lat_min = 1; lat_max = 1; i_inst_ready = 1'b1;
        repeat (8) cycle();
        i_redirect = 1'b1; i_redirect_pc = 14'h0200;
        dlv.delete();
        repeat (10) cycle();
        checks++;
        if (dlv.size() == 0 || dlv[0] !== 14'h0200) begin
            failures++;
            $display("FAIL collide_lat1: got %h expected 0200", (dlv.size() > 0) ? dlv[0] : 14'h0);
        end
        lat_min = 2; lat_max = 2;
        repeat (6) cycle();
        i_redirect = 1'b1; i_redirect_pc = 14'h0300;
        dlv.delete();
        repeat (12) cycle();
        checks++;
        if (dlv.size() == 0 || dlv[0] !== 14'h0300) begin
            failures++;
            $display("FAIL collide_lat2: got %h expected 0300", (dlv.size() > 0) ? dlv[0] : 14'h0);
        end
    endtask

    task automatic test_wrap();
        apply_reset(1);
        rand_gnt = 0; lat_min = 1; lat_max = 1; i_inst_ready = 1'b1;
        cycle();
        i_redirect = 1'b1; i_redirect_pc = 14'h3FFE;
        dlv.delete();
        repeat (10) cycle();
        checks++;
        if (dlv.size() < 4 || dlv[0] !== 14'h3FFE || dlv[1] !== 14'h3FFF ||
            dlv[2] !== 14'h0000 || dlv[3] !== 14'h0001) begin
            failures++;
            $display("FAIL pc_wrap: got %0d pops first=%h expected 3FFE 3FFF 0000 0001",
                     dlv.size(), (dlv.size() > 0) ? dlv[0] : 14'h0);
        end
    endtask

    task automatic test_midreset();
        apply_reset(1);
        rand_gnt = 0; lat_min = 1; lat_max = 2; i_inst_ready = 1'b0;
        repeat (5) cycle();
        i_redirect = 1'b1; i_redirect_pc = 14'h0555;
        repeat (8) cycle();
        apply_reset(2);
        i_inst_ready = 1'b1;
        dlv.delete();
        repeat (10) cycle();
        checks++;
        if (dlv.size() == 0 || dlv[0] !== RST_PC) begin
            failures++;
            $display("FAIL restart_pc: got %h expected %h", (dlv.size() > 0) ? dlv[0] : 14'h0, RST_PC);
        end
    endtask

    task automatic test_random();
        apply_reset(1);
        rand_gnt = 1; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 1500; k++) begin
            i_inst_ready = ($urandom_range(3, 0) != 0);
            if (k > 0 && $urandom_range(15, 0) == 0) begin
                i_redirect    = 1'b1;
                i_redirect_pc = ($urandom_range(3, 0) == 0) ? 14'h3FFF : PW'($urandom);
            end
            cycle();
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; n_issue = 0;
        rand_gnt = 0; lat_min = 1; lat_max = 1;
        rst_n = 1'b0; i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_inst_ready = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_drain();
        test_redirect_collide();
        test_wrap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
